// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: packet-level round-robin arbiter that shares one byte-wide
// UART transmitter between NUM_REQ message sources. A requester owns the
// transmitter for a whole message; ownership rotates between messages and a
// watchdog releases the channel when either side stops making progress.
module uart_msg_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   uart_enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_byte,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   timeout_err
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WDW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_start_q, tx_start_d;
  logic                timeout_err_q, timeout_err_d;
  logic                last_flag_q, last_flag_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     last_owner_q, last_owner_d;
  logic [WDW-1:0]      wd_q, wd_d;

  logic [IDXW-1:0]     arb_idx_c;
  logic                arb_hit_c;
  int unsigned         arb_cand_c;
  logic                arb_go_c;
  logic                owner_valid_c;
  logic                owner_last_c;
  logic [7:0]          lane_byte_c;
  logic [NUM_REQ-1:0]  owner_onehot_c;
  logic                wd_expire_c;

  // Round-robin search: first valid requester after the previous owner
  always_comb begin
    arb_idx_c  = '0;
    arb_hit_c  = 1'b0;
    arb_cand_c = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      arb_cand_c = 32'(last_owner_q) + k;
      if (arb_cand_c >= NUM_REQ) arb_cand_c = arb_cand_c - NUM_REQ;
      if (!arb_hit_c && req_valid[IDXW'(arb_cand_c)]) begin
        arb_hit_c = 1'b1;
        arb_idx_c = IDXW'(arb_cand_c);
      end
    end
  end

  assign arb_go_c       = uart_enable && !tx_busy && arb_hit_c;
  assign owner_valid_c  = req_valid[owner_q];
  assign owner_last_c   = req_last[owner_q];
  assign lane_byte_c    = req_data[{owner_q, 3'b000} +: 8];
  assign owner_onehot_c = NUM_REQ'(1) << owner_q;
  assign wd_expire_c    = (wd_q == WD_LIMIT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a tx_done in WAIT counts as progress ahead of the watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_go_c) state_d = ST_SEND;
      ST_SEND: begin
        if (!uart_enable)       state_d = ST_IDLE;
        else if (owner_valid_c) state_d = ST_WAIT;
        else if (wd_expire_c)   state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (tx_done)          state_d = last_flag_q ? ST_IDLE : ST_SEND;
        else if (wd_expire_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: grant, byte capture, pulses, rotation, watchdog
  always_comb begin
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    tx_byte_d     = tx_byte_q;
    last_flag_d   = last_flag_q;
    tx_start_d    = 1'b0;
    req_ready_d   = '0;
    timeout_err_d = 1'b0;
    wd_d          = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_go_c) begin
          owner_d = arb_idx_c;
          grant_d = NUM_REQ'(1) << arb_idx_c;
        end
      end
      ST_SEND: begin
        if (!uart_enable) begin
          grant_d = '0;
        end else if (owner_valid_c) begin
          tx_byte_d   = lane_byte_c;
          last_flag_d = owner_last_c;
          tx_start_d  = 1'b1;
          req_ready_d = owner_onehot_c;
        end else if (wd_expire_c) begin
          timeout_err_d = 1'b1;
          grant_d       = '0;
          last_owner_d  = owner_q;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (last_flag_q) begin
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end else if (wd_expire_c) begin
          timeout_err_d = 1'b1;
          grant_d       = '0;
          last_owner_d  = owner_q;
        end
      end
      default: grant_d = '0;
    endcase

    if ((state_d == ST_SEND || state_d == ST_WAIT) && state_d != state_q) begin
      wd_d = '0;
    end else if (state_q != ST_IDLE) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  // Registered outputs and arbitration bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q       <= '0;
      req_ready_q   <= '0;
      tx_byte_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      last_flag_q   <= 1'b0;
      owner_q       <= '0;
      last_owner_q  <= IDXW'(NUM_REQ - 1);
      wd_q          <= '0;
    end else begin
      grant_q       <= grant_d;
      req_ready_q   <= req_ready_d;
      tx_byte_q     <= tx_byte_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      last_flag_q   <= last_flag_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      wd_q          <= wd_d;
    end
  end

  assign grant       = grant_q;
  assign req_ready   = req_ready_q;
  assign tx_byte     = tx_byte_q;
  assign tx_start    = tx_start_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Scoreboard bench for uart_msg_arbiter with two requesters and a short
// watchdog. Stimulus queues bytes on requester lanes and pushes the expected
// transmit order; a monitor pops and compares on every tx_start pulse.
module tb_uart_msg_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic       lane;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic                 uart_enable;
  logic                 busy_force;
  logic                 model_busy;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 sv0, sv1, sl0, sl1;
  logic [7:0]           sd0, sd1;
  logic [NUM_REQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0]           tx_byte;
  logic                 tx_start, timeout_err;

  assign req_valid = {sv1, sv0};
  assign req_last  = {sl1, sl0};
  assign req_data  = {sd1, sd0};
  assign tx_busy   = model_busy | busy_force;

  uart_msg_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_enable (uart_enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .timeout_err (timeout_err)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  exp_t exp_q[$];
  int   rise_cyc0 = 0;
  int   first_start_cyc = 0;
  int   last_start_cyc = 0;
  int   start_cnt = 0;
  int   ready0_cnt = 0;
  int   to_cnt = 0;
  logic [7:0] msg [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input logic lane);
    oh = NUM_REQ'(1) << lane;
  endfunction

  task automatic push_byte(input int lane, input logic [7:0] d, input logic l, input bit expect_it);
    exp_t e;
    if (lane == 0) src_q0.push_back({l, d});
    else           src_q1.push_back({l, d});
    if (expect_it) begin
      e.lane = lane[0];
      e.last = l;
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_msg(input int lane, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) push_byte(lane, base + 8'(i), (i == n - 1), 1'b1);
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       cond = (grant == 2'b10);
      1:       cond = tx_start;
      2:       cond = timeout_err;
      default: cond = (exp_q.size() == 0) && (grant == '0) && !tx_busy;
    endcase
  endfunction

  // Bounded wait, polled 2 time units after each rising edge
  task automatic wait_cond(input int sel, input int budget, input string name);
    int n = 0;
    bit hit;
    hit = cond(sel);
    while (!hit && n < budget) begin
      @(posedge clk); #2;
      n++;
      hit = cond(sel);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: condition not reached within %0d cycles (pending=%0d)", name, budget, exp_q.size());
    end
  endtask

  // Transmitter model: tx_done two cycles after tx_start is seen
  initial begin
    int cnt;
    cnt = 0;
    model_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        cnt = 0;
        model_busy = 1'b0;
        tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            tx_done = 1'b1;
            model_busy = 1'b0;
          end
        end
        if (tx_start) begin
          cnt = 2;
          model_busy = 1'b1;
        end
      end
    end
  end

  // Requester lanes: present queue head, advance on req_ready
  initial begin
    bit nv;
    sv0 = 1'b0; sv1 = 1'b0; sl0 = 1'b0; sl1 = 1'b0; sd0 = 8'h00; sd1 = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (sv0 && req_ready[0] && src_q0.size() != 0) void'(src_q0.pop_front());
      nv = (src_q0.size() != 0);
      if (nv && !sv0) rise_cyc0 = cyc;
      sv0 = nv;
      if (nv) begin sl0 = src_q0[0][8]; sd0 = src_q0[0][7:0]; end
      if (sv1 && req_ready[1] && src_q1.size() != 0) void'(src_q1.pop_front());
      nv = (src_q1.size() != 0);
      sv1 = nv;
      if (nv) begin sl1 = src_q1[0][8]; sd1 = src_q1[0][7:0]; end
    end
  end

  // Monitor: scoreboard pops on tx_start, release and pulse invariants
  initial begin
    bit   in_msg, cur_lane, cur_last, rel_pend, prev_start, prev_to, bad;
    exp_t e;
    in_msg = 0; cur_lane = 0; cur_last = 0; rel_pend = 0; prev_start = 0; prev_to = 0;
    forever begin
      @(posedge clk); #3;
      if (!reset_n) begin
        in_msg = 0; cur_last = 0; rel_pend = 0; prev_start = 0; prev_to = 0;
      end else begin
        bad = ((grant & (grant - 2'd1)) != '0) || ((req_ready & (req_ready - 2'd1)) != '0) ||
              (tx_start && prev_start) || (timeout_err && prev_to) ||
              ((req_ready != '0) && !tx_start);
        check("invariants", 32'(bad), 32'd0);
        if (rel_pend) begin
          check("release_grant", 32'(grant), 32'd0);
          rel_pend = 0;
        end
        if (req_ready[0]) ready0_cnt++;
        if (tx_start) begin
          start_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_tx_start", 32'(tx_byte), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(e.data));
            check("grant_at_start", 32'(grant), 32'(oh(e.lane)));
            check("req_ready", 32'(req_ready), 32'(oh(e.lane)));
            if (in_msg && cur_lane == e.lane) check("byte_spacing", 32'(cyc - last_start_cyc), 32'd4);
            else first_start_cyc = cyc;
            in_msg = !e.last;
            cur_lane = e.lane;
            cur_last = e.last;
          end
          last_start_cyc = cyc;
        end
        if (tx_done && cur_last) begin
          rel_pend = 1;
          cur_last = 0;
        end
        if (timeout_err) begin
          to_cnt++;
          in_msg = 0;
        end
        prev_start = tx_start;
        prev_to = timeout_err;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Directed stimulus
  initial begin
    int  s0, r0, t0;
    bit  seen;
    msg = '{8'h41, 8'h20, 8'h34, 8'h2C, 8'h20, 8'h34, 8'h34, 8'h30, 8'h0D, 8'h0A};
    reset_n = 1'b1;
    uart_enable = 1'b1;
    busy_force = 1'b0;
    #2 reset_n = 1'b0;

    // Round-robin: both lanes loaded during reset, expected order 0,1,0,1
    push_msg(0, 8'h10, 3);
    push_msg(1, 8'h20, 3);
    push_msg(0, 8'h30, 3);
    push_msg(1, 8'h40, 3);
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx_byte", 32'(tx_byte), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    wait_cond(3, 400, "rr_complete");
    check("rr_start_count", 32'(start_cnt), 32'd12);

    // Single source, 10-byte message on lane 0
    repeat (2) @(posedge clk);
    #2;
    s0 = start_cnt;
    r0 = ready0_cnt;
    for (int i = 0; i < 10; i++) push_byte(0, msg[i], (i == 9), 1'b1);
    wait_cond(3, 300, "single_complete");
    check("single_start_count", 32'(start_cnt - s0), 32'd10);
    check("single_ready_count", 32'(ready0_cnt - r0), 32'd10);
    check("first_start_latency", 32'(first_start_cyc - rise_cyc0), 32'd2);

    // Gating: disabled, then transmitter busy, then released
    repeat (2) @(posedge clk);
    #2;
    uart_enable = 1'b0;
    push_byte(0, 8'h55, 1'b1, 1'b1);
    seen = 0;
    repeat (100) begin
      @(posedge clk); #2;
      if (grant != '0) seen = 1;
    end
    check("gate_disabled_grant", 32'(seen), 32'd0);
    busy_force = 1'b1;
    uart_enable = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (grant != '0) seen = 1;
    end
    check("gate_busy_grant", 32'(seen), 32'd0);
    busy_force = 1'b0;
    @(posedge clk); #2;
    check("gate_release_grant", 32'(grant), 32'b01);
    wait_cond(3, 100, "gate_complete");

    // Owner stall: lane 1 sends one non-final byte then goes quiet
    repeat (2) @(posedge clk);
    #2;
    t0 = to_cnt;
    push_byte(1, 8'h31, 1'b0, 1'b1);
    wait_cond(0, 50, "stall_grant_lane1");
    push_byte(0, 8'h41, 1'b0, 1'b1);
    push_byte(0, 8'h42, 1'b1, 1'b1);
    wait_cond(2, 100, "stall_timeout_seen");
    check("stall_timeout_latency", 32'(cyc - last_start_cyc), 32'd19);
    check("stall_grant_cleared", 32'(grant), 32'd0);
    @(posedge clk); #2;
    check("stall_next_grant", 32'(grant), 32'b01);
    wait_cond(3, 100, "stall_complete");
    check("stall_timeout_once", 32'(to_cnt - t0), 32'd1);

    // Reset during WAIT: lane 0 owned last, so only reset restores lane 0 priority
    repeat (2) @(posedge clk);
    #2;
    push_byte(0, 8'h61, 1'b0, 1'b0);
    push_byte(0, 8'h62, 1'b1, 1'b0);
    wait_cond(1, 50, "rst_first_start");
    check("rst_pre_byte", 32'(tx_byte), 32'h61);
    reset_n = 1'b0;
    #1;
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    push_byte(0, 8'h70, 1'b1, 1'b1);
    push_byte(1, 8'h71, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    check("rst_first_owner", 32'(grant), 32'b01);
    wait_cond(3, 100, "rst_complete");
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_msg_arbiter.md
# uart_msg_arbiter

Packet-level round-robin arbiter sharing the single byte-wide UART transmitter between several message sources (note reporter, status/heartbeat, debug dump). Each requester presents a byte stream with a last-byte marker. The arbiter locks the transmitter to one requester for a whole message, drives the transmitter's `tx_data`/`send` inputs, and paces bytes on the transmitter's `tx_done` pulse. Between messages, ownership rotates, and a watchdog frees the channel if a requester or the transmitter stalls.

## Interface
Parameters:
- `NUM_REQ`, 2 — number of requesters, legal range 2..4
- `TIMEOUT_CYCLES`, 1_000_000 — cycles without progress before a message is aborted (20 ms at 50 MHz)

Ports:
- `clk`  in  1 — system clock (50 MHz)
- `reset_n`  in  1 — asynchronous, active-low reset
- `uart_enable`  in  1 — transmit enable (mirrors the transmitter's `tx_enable`)
- `req_valid`  in  NUM_REQ — requester i has a byte on its data lane
- `req_data`  in  8*NUM_REQ — byte lanes; lane i is bits [8i+7:8i]
- `req_last`  in  NUM_REQ — lane i byte is the final byte of its message
- `req_ready`  out  NUM_REQ — one-cycle pulse: lane i byte consumed
- `grant`  out  NUM_REQ — one-hot current owner; all-zero when idle
- `tx_byte`  out  8 — byte to the transmitter
- `tx_start`  out  1 — one-cycle send pulse to the transmitter
- `tx_busy`  in  1 — transmitter busy
- `tx_done`  in  1 — one-cycle pulse, byte finished on the line
- `timeout_err`  out  1 — one-cycle pulse when a message is aborted by the watchdog

## Operation
- Reset values:
  - `tx_byte`=0x00, `tx_start`=0, `req_ready`=0, `grant`=0, `timeout_err`=0
  - state IDLE
  - `last_owner`=NUM_REQ-1, so requester 0 has first priority
  - watchdog counter = 0
- IDLE:
  - Arbitration happens only when `uart_enable`=1, `tx_busy`=0 and any `req_valid` is high.
  - Owner = first valid index scanning `last_owner`+1, +2, … modulo NUM_REQ.
  - Register the owner one-hot into `grant` and go to SEND.
- SEND:
  - If `uart_enable`=0: clear `grant` and go to IDLE. Any partial message is abandoned with no error pulse; ownership does not rotate.
  - Else if `req_valid[owner]`=1: capture `req_data` lane into `tx_byte` and capture `req_last[owner]` into the last flag. Next cycle `tx_start`=1 and `req_ready[owner]`=1 for exactly one cycle. Go to WAIT.
  - Else: hold the grant and wait. A requester may pause mid-message.
- WAIT:
  - On `tx_done`=1 with last flag set: clear `grant`, set `last_owner`=owner, go to IDLE.
  - On `tx_done`=1 with last flag clear: go to SEND.
  - `uart_enable` falling while in WAIT is ignored until `tx_done` arrives.
- Watchdog:
  - The counter clears on every entry to SEND or WAIT and increments each cycle spent in SEND or WAIT.
  - On reaching TIMEOUT_CYCLES-1: pulse `timeout_err`, clear `grant`, set `last_owner`=owner so the staller loses priority, go to IDLE.
  - The counter is inactive in IDLE.
- Handshake rules:
  - `tx_done` outside WAIT is ignored.
  - `req_valid`/`req_data`/`req_last` of non-owners are ignored while a grant is held.
  - The owner must hold its lane stable until it samples `req_ready` high; it may change the lane in the cycle after.
  - `req_valid` may drop without `req_ready`, i.e. a request may be withdrawn before acceptance.
- A single-byte message is a byte with `req_last`=1 on its first byte.

## Timing
- Arbitration latency:
  - `req_valid` high in IDLE at edge T0 → `grant` high after T0 (cycle T1).
  - Byte captured at T1 → `tx_start`/`req_ready` high in cycle T2.
- Inter-byte gap:
  - `tx_done` sampled at Tk → SEND in Tk+1 → next `tx_start` in Tk+2, if the owner is valid.
- Release:
  - Final `tx_done` at Tk → `grant`=0 in Tk+1.
  - Next arbitration is possible at Tk+1, subject to `tx_busy`=0.
- `tx_start`, `req_ready` and `timeout_err` are never high for two consecutive cycles.
- At most one bit of `req_ready` and of `grant` is ever high.
- Reset asserted mid-message:
  - All outputs return to reset values immediately (asynchronously).
  - The in-flight byte is abandoned; the transmitter is reset by the same `reset_n`.

## Test plan
- **Single source:** req 0 sends the 10-byte message "A 4, 440\r\n" with `req_last` on 0x0A. Required: 10 `tx_start` pulses carrying those bytes in order; 10 `req_ready[0]` pulses; `grant`=0b01 throughout; `grant`=0 one cycle after the 10th `tx_done`.
- **Round-robin:** reqs 0 and 1 both valid from reset, each sending 3-byte messages, repeated twice. Required: message order 0,1,0,1; no byte interleaving; `grant` never 0b11.
- **Timing check:** model `tx_done` as 2 cycles after `tx_start`. Required: `tx_start` spacing exactly 4 cycles within a message; first `tx_start` exactly 2 cycles after `req_valid` rises in IDLE.
- **Owner stall:** `TIMEOUT_CYCLES`=16; req 1 sends 1 byte (not last) and then drops `req_valid`. Required: `timeout_err` pulses exactly once, 16 cycles after SEND entry; `grant`=0; a pending req 0 is granted next.
- **Gating:** `uart_enable`=0 with req 0 valid gives no grant for 100 cycles. Then hold `tx_busy`=1 with enable high: still no grant. Release `tx_busy` → grant 1 cycle later.
- **Reset mid-message:** assert `reset_n`=0 during WAIT. Required: all outputs are 0 in the same cycle; after release, req 0 wins arbitration first.
